sdram_arbiter: RTL and testbench

- Request stage directly upstream of the 8-phase SDRAM controller.
- Arbitrates between the CPU port and the video fetch port, one access per sync-aligned slot.
- Presents address, data, byte strobes and oe/we to the controller, held stable for the whole slot.
- Returns read data plus a one-clock ack to the owning requester; periodically forces an idle slot so the controller issues auto-refresh.

---
 rtl/sdram_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//
// Request stage that sits directly in front of the 8-phase SDRAM controller.
// It shares one controller between a CPU port and a video fetch port, granting
// at most one access per sync-aligned slot. The granted request is registered
// onto mem_* at the slot boundary and held for the whole slot (controller
// phases 0..7). At the following boundary the access completes: the owner gets
// a one-clock ack and, for reads, the controller's data.
//
// After REFRESH_GAP back-to-back granted slots, one slot is forced idle so the
// controller can issue its auto-refresh.
//
// Ports:
//   clk        SDRAM clock, shared with the controller
//   reset_n    synchronous active-low reset
//   sync       one-clock slot reference pulse from the controller timing
//   cpu_*      CPU request/response port (level request held until cpu_ack)
//   vid_*      video read request/response port (level request held until vid_ack)
//   mem_*      controller request bus (mem_dout is the controller's read data)

module sdram_arbiter #(
  parameter int REFRESH_GAP = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sync,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_addr,
  input  logic [1:0]  cpu_ds,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,

  input  logic        vid_req,
  input  logic [23:0] vid_addr,
  output logic [15:0] vid_dout,
  output logic        vid_ack,

  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_ds,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic [15:0] mem_dout
);

  // Refresh run length as a 4-bit constant so it compares cleanly with the
  // counter; legal values are 1..15.
  localparam logic [3:0] GAP = 4'(REFRESH_GAP);

  // Owner of the slot currently in flight.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_t;

  owner_t      owner_q,    owner_d;
  logic        slot_rd_q,  slot_rd_d;
  logic [2:0]  ph_q,       ph_d;
  logic [3:0]  ref_cnt_q,  ref_cnt_d;

  logic [23:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_din_q,  mem_din_d;
  logic [1:0]  mem_ds_q,   mem_ds_d;
  logic        mem_oe_q,   mem_oe_d;
  logic        mem_we_q,   mem_we_d;

  logic        cpu_ack_q,  cpu_ack_d;
  logic        vid_ack_q,  vid_ack_d;
  logic [15:0] cpu_dout_q, cpu_dout_d;
  logic [15:0] vid_dout_q, vid_dout_d;

  logic        boundary;
  logic        vid_elig;
  logic        cpu_elig;

  // A slot boundary is a sync seen while the phase counter sits at 7. Syncs
  // arriving at any other phase are ignored, which also lets the counter park
  // at 7 when the controller stretches its slot.
  assign boundary = (ph_q == 3'd7) && sync;

  // The requester whose access completes at this boundary still has its req
  // high (it only sees ack now), so that req is stale and must not win again.
  assign vid_elig = vid_req && (owner_q != OWN_VID);
  assign cpu_elig = cpu_req && (owner_q != OWN_CPU);

  // State register for the whole stage, including the owner FSM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ph_q       <= 3'd7;
      owner_q    <= OWN_NONE;
      slot_rd_q  <= 1'b0;
      ref_cnt_q  <= 4'd0;
      mem_addr_q <= 24'd0;
      mem_din_q  <= 16'd0;
      mem_ds_q   <= 2'd0;
      mem_oe_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vid_ack_q  <= 1'b0;
      cpu_dout_q <= 16'd0;
      vid_dout_q <= 16'd0;
    end else begin
      ph_q       <= ph_d;
      owner_q    <= owner_d;
      slot_rd_q  <= slot_rd_d;
      ref_cnt_q  <= ref_cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_ds_q   <= mem_ds_d;
      mem_oe_q   <= mem_oe_d;
      mem_we_q   <= mem_we_d;
      cpu_ack_q  <= cpu_ack_d;
      vid_ack_q  <= vid_ack_d;
      cpu_dout_q <= cpu_dout_d;
      vid_dout_q <= vid_dout_d;
    end
  end

  // Next-state logic. Everything holds between boundaries except the phase
  // counter and the ack pulses, which drop back to 0 one clock after rising.
  // At a boundary the in-flight slot completes first, then the next slot is
  // granted (or forced idle for refresh) within the same edge.
  always_comb begin
    ph_d       = ph_q;
    owner_d    = owner_q;
    slot_rd_d  = slot_rd_q;
    ref_cnt_d  = ref_cnt_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_ds_d   = mem_ds_q;
    mem_oe_d   = mem_oe_q;
    mem_we_d   = mem_we_q;
    cpu_ack_d  = 1'b0;
    vid_ack_d  = 1'b0;
    cpu_dout_d = cpu_dout_q;
    vid_dout_d = vid_dout_q;

    // Free-running except at 7, where it waits for the controller's sync.
    if ((ph_q != 3'd7) || sync) begin
      ph_d = ph_q + 3'd1;
    end

    if (boundary) begin
      // Complete the slot in flight. Read data has been stable on mem_dout
      // since controller phase 6, so it is captured right here.
      unique case (owner_q)
        OWN_CPU: begin
          cpu_ack_d = 1'b1;
          if (slot_rd_q) begin
            cpu_dout_d = mem_dout;
          end
        end
        OWN_VID: begin
          vid_ack_d  = 1'b1;
          vid_dout_d = mem_dout;
        end
        default: ;
      endcase

      // Idle unless a grant below says otherwise; address, data and strobes
      // keep their old values on an idle slot.
      owner_d   = OWN_NONE;
      slot_rd_d = 1'b0;
      mem_oe_d  = 1'b0;
      mem_we_d  = 1'b0;

      if (ref_cnt_q == GAP) begin
        // Forced idle slot: the controller refreshes when neither oe nor we.
        ref_cnt_d = 4'd0;
      end else if (vid_elig) begin
        owner_d    = OWN_VID;
        slot_rd_d  = 1'b1;
        mem_oe_d   = 1'b1;
        mem_addr_d = vid_addr;
        mem_ds_d   = 2'b11;
        ref_cnt_d  = ref_cnt_q + 4'd1;
      end else if (cpu_elig) begin
        owner_d    = OWN_CPU;
        slot_rd_d  = ~cpu_we;
        mem_we_d   = cpu_we;
        mem_oe_d   = ~cpu_we;
        mem_addr_d = cpu_addr;
        mem_ds_d   = cpu_ds;
        mem_din_d  = cpu_din;
        ref_cnt_d  = ref_cnt_q + 4'd1;
      end else begin
        // A naturally idle slot also lets the controller refresh.
        ref_cnt_d = 4'd0;
      end
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_ds   = mem_ds_q;
  assign mem_oe   = mem_oe_q;
  assign mem_we   = mem_we_q;
  assign cpu_ack  = cpu_ack_q;
  assign vid_ack  = vid_ack_q;
  assign cpu_dout = cpu_dout_q;
  assign vid_dout = vid_dout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//
// Directed bench for sdram_arbiter. A slot-level model tracks when a sync is
// accepted as a slot boundary (at least 8 clocks after the previous one, or the
// first sync after reset), who owns each slot and what the controller bus must
// show; one compare step checks every DUT output against it on each clock.
// Literal expectations after each scenario pin the model to hand-worked values.

module tb_sdram_arbiter;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync;
  logic        cpu_req;
  logic        cpu_we;
  logic [23:0] cpu_addr;
  logic [1:0]  cpu_ds;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_ack;
  logic        vid_req;
  logic [23:0] vid_addr;
  logic [15:0] vid_dout;
  logic        vid_ack;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_ds;
  logic        mem_oe;
  logic        mem_we;
  logic [15:0] mem_dout;

  always #5 clk = ~clk;

  sdram_arbiter #(.REFRESH_GAP(GAP)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sync     (sync),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_ds   (cpu_ds),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_ack  (cpu_ack),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_dout (vid_dout),
    .vid_ack  (vid_ack),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_ds   (mem_ds),
    .mem_oe   (mem_oe),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  int total = 0;
  int bad   = 0;

  // Slot-level model state: clocks since the last accepted boundary, slot
  // owner (0 none, 1 cpu, 2 vid), whether it is a read, and the length of the
  // current run of granted slots.
  int          sinceBnd;
  int          mOwner;
  bit          mRead;
  int          mRun;
  logic [23:0] expAddr;
  logic [15:0] expDin;
  logic [1:0]  expDs;
  logic        expOe;
  logic        expWe;
  logic        expCpuAck;
  logic        expVidAck;
  logic [15:0] expCpuDout;
  logic [15:0] expVidDout;

  // Per-slot observations used by the literal checks.
  logic [15:0] nextData;
  int          curIdx;
  int          oeTicks;
  int          weTicks;
  int          cpuAckCnt;
  int          vidAckCnt;
  int          vidAckAt;
  logic        snapOe;
  logic        snapWe;
  logic [23:0] snapAddr;
  logic [1:0]  snapDs;
  logic [15:0] snapDin;
  int          pattern [10];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Advance the model across one rising edge using the inputs that the DUT
  // sampled at that same edge.
  task automatic modelStep();
    bit bnd;
    bit vEl;
    bit cEl;
    if (!reset_n) begin
      sinceBnd   = 8;
      mOwner     = 0;
      mRead      = 1'b0;
      mRun       = 0;
      expAddr    = '0;
      expDin     = '0;
      expDs      = '0;
      expOe      = 1'b0;
      expWe      = 1'b0;
      expCpuAck  = 1'b0;
      expVidAck  = 1'b0;
      expCpuDout = '0;
      expVidDout = '0;
    end else begin
      expCpuAck = 1'b0;
      expVidAck = 1'b0;
      bnd = sync && (sinceBnd >= 8);
      if (bnd) sinceBnd = 1;
      else if (sinceBnd < 8) sinceBnd++;
      if (bnd) begin
        if (mOwner == 1) begin
          expCpuAck = 1'b1;
          if (mRead) expCpuDout = mem_dout;
        end
        if (mOwner == 2) begin
          expVidAck  = 1'b1;
          expVidDout = mem_dout;
        end
        vEl = vid_req && (mOwner != 2);
        cEl = cpu_req && (mOwner != 1);
        expOe  = 1'b0;
        expWe  = 1'b0;
        mRead  = 1'b0;
        mOwner = 0;
        if (mRun == GAP) begin
          mRun = 0;
        end else if (vEl) begin
          mOwner  = 2;
          mRead   = 1'b1;
          expOe   = 1'b1;
          expAddr = vid_addr;
          expDs   = 2'b11;
          mRun++;
        end else if (cEl) begin
          mOwner  = 1;
          mRead   = !cpu_we;
          expOe   = !cpu_we;
          expWe   = cpu_we;
          expAddr = cpu_addr;
          expDs   = cpu_ds;
          expDin  = cpu_din;
          mRun++;
        end else begin
          mRun = 0;
        end
      end
    end
  endtask

  // Compare every output with the model and collect per-slot statistics.
  task automatic checkOutput();
    checkVal("mem_addr", 32'(mem_addr), 32'(expAddr));
    checkVal("mem_din", 32'(mem_din), 32'(expDin));
    checkVal("mem_ds", 32'(mem_ds), 32'(expDs));
    checkVal("mem_oe", 32'(mem_oe), 32'(expOe));
    checkVal("mem_we", 32'(mem_we), 32'(expWe));
    checkVal("oe_we_exclusive", 32'(mem_oe & mem_we), 32'd0);
    checkVal("cpu_ack", 32'(cpu_ack), 32'(expCpuAck));
    checkVal("vid_ack", 32'(vid_ack), 32'(expVidAck));
    checkVal("cpu_dout", 32'(cpu_dout), 32'(expCpuDout));
    checkVal("vid_dout", 32'(vid_dout), 32'(expVidDout));
    if (mem_oe === 1'b1) oeTicks++;
    if (mem_we === 1'b1) weTicks++;
    if (cpu_ack === 1'b1) cpuAckCnt++;
    if (vid_ack === 1'b1) begin
      vidAckCnt++;
      if (vidAckAt < 0) vidAckAt = curIdx;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  // One controller slot of the given length: sync on the first clock, an
  // optional stray sync mid-slot, and read data driven from phase 6 onward.
  task automatic applyStimulus(input int period, input int strayAt);
    oeTicks   = 0;
    weTicks   = 0;
    cpuAckCnt = 0;
    vidAckCnt = 0;
    vidAckAt  = -1;
    for (int i = 0; i < period; i++) begin
      curIdx = i;
      sync = (i == 0) || (i == strayAt);
      if (i == 1) mem_dout = 16'h5A5A;
      if (i == period - 2) mem_dout = nextData;
      tick();
      if (i == 0) begin
        snapOe   = mem_oe;
        snapWe   = mem_we;
        snapAddr = mem_addr;
        snapDs   = mem_ds;
        snapDin  = mem_din;
      end
    end
    sync = 1'b0;
  endtask

  initial begin
    int expPat [10];
    expPat = '{2, 1, 2, 1, 0, 2, 1, 2, 1, 0};

    reset_n  = 1'b0;
    sync     = 1'b0;
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    cpu_addr = '0;
    cpu_ds   = '0;
    cpu_din  = '0;
    vid_req  = 1'b0;
    vid_addr = '0;
    mem_dout = '0;
    nextData = '0;
    curIdx   = 0;
    cpuAckCnt = 0;
    vidAckCnt = 0;
    vidAckAt  = -1;

    // Reset state
    repeat (3) tick();
    checkVal("rst_mem_oe", 32'(mem_oe), 32'd0);
    checkVal("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkVal("rst_mem_ds", 32'(mem_ds), 32'd0);
    checkVal("rst_vid_dout", 32'(vid_dout), 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();

    // Video read
    $display("[TB] video read");
    vid_req  = 1'b1;
    vid_addr = 24'h001234;
    nextData = 16'hBEEF;
    applyStimulus(8, -1);
    checkVal("vid_grant_oe", 32'(snapOe), 32'd1);
    checkVal("vid_grant_addr", 32'(snapAddr), 32'h001234);
    checkVal("vid_grant_ds", 32'(snapDs), 32'h3);
    checkVal("vid_oe_ticks", 32'(oeTicks), 32'd8);
    nextData = 16'h1111;
    applyStimulus(8, -1);
    checkVal("vid_ack_count", 32'(vidAckCnt), 32'd1);
    checkVal("vid_ack_at", 32'(vidAckAt), 32'd0);
    checkVal("vid_dout_beef", 32'(vid_dout), 32'hBEEF);
    checkVal("vid_stale_oe", 32'(snapOe), 32'd0);
    vid_req = 1'b0;
    applyStimulus(8, -1);

    // CPU write
    $display("[TB] cpu write");
    cpu_req  = 1'b1;
    cpu_we   = 1'b1;
    cpu_addr = 24'h0ABCDE;
    cpu_ds   = 2'b01;
    cpu_din  = 16'h00A5;
    nextData = 16'h7777;
    applyStimulus(8, -1);
    checkVal("wr_we", 32'(snapWe), 32'd1);
    checkVal("wr_oe", 32'(snapOe), 32'd0);
    checkVal("wr_ds", 32'(snapDs), 32'h1);
    checkVal("wr_din", 32'(snapDin), 32'h00A5);
    checkVal("wr_addr", 32'(snapAddr), 32'h0ABCDE);
    checkVal("wr_we_ticks", 32'(weTicks), 32'd8);
    applyStimulus(8, -1);
    checkVal("wr_ack_count", 32'(cpuAckCnt), 32'd1);
    checkVal("wr_cpu_dout", 32'(cpu_dout), 32'd0);
    cpu_req = 1'b0;
    applyStimulus(8, -1);

    // Contention with refresh: both requests held high
    $display("[TB] contention and refresh");
    cpu_we   = 1'b0;
    cpu_addr = 24'h0C0000;
    cpu_ds   = 2'b11;
    vid_addr = 24'h0F0000;
    cpu_req  = 1'b1;
    vid_req  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      nextData = 16'hC000 + 16'(k);
      applyStimulus(8, -1);
      if (snapOe)
        pattern[k] = (snapAddr == 24'h0F0000) ? 2 : 1;
      else
        pattern[k] = snapWe ? 3 : 0;
    end
    for (int k = 0; k < 10; k++) begin
      checkVal($sformatf("pattern_%0d", k), 32'(pattern[k]), 32'(expPat[k]));
    end
    cpu_req = 1'b0;
    vid_req = 1'b0;
    applyStimulus(8, -1);

    // Stretched sync with a stray mid-slot sync
    $display("[TB] stretched sync");
    vid_req  = 1'b1;
    vid_addr = 24'h00BEAD;
    nextData = 16'h1357;
    applyStimulus(12, 5);
    checkVal("str_oe_ticks", 32'(oeTicks), 32'd12);
    checkVal("str_grant_addr", 32'(snapAddr), 32'h00BEAD);
    nextData = 16'h0000;
    applyStimulus(12, -1);
    checkVal("str_ack_count", 32'(vidAckCnt), 32'd1);
    checkVal("str_ack_at", 32'(vidAckAt), 32'd0);
    checkVal("str_vid_dout", 32'(vid_dout), 32'h1357);
    vid_req = 1'b0;
    applyStimulus(12, -1);

    // Reset in the middle of a CPU read slot
    $display("[TB] reset mid-slot");
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 24'h00C0DE;
    cpu_ds   = 2'b10;
    sync     = 1'b1;
    tick();
    sync = 1'b0;
    checkVal("rmid_grant_oe", 32'(mem_oe), 32'd1);
    repeat (3) tick();
    cpuAckCnt = 0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    checkVal("rmid_no_ack", 32'(cpuAckCnt), 32'd0);
    checkVal("rmid_oe_reset", 32'(mem_oe), 32'd0);
    checkVal("rmid_addr_reset", 32'(mem_addr), 32'd0);
    nextData = 16'h2468;
    applyStimulus(8, -1);
    checkVal("rmid_regrant_oe", 32'(snapOe), 32'd1);
    checkVal("rmid_regrant_addr", 32'(snapAddr), 32'h00C0DE);
    checkVal("rmid_regrant_ds", 32'(snapDs), 32'h2);
    applyStimulus(8, -1);
    checkVal("rmid_ack_count", 32'(cpuAckCnt), 32'd1);
    checkVal("rmid_cpu_dout", 32'(cpu_dout), 32'h2468);
    cpu_req = 1'b0;
    applyStimulus(8, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
